// File: rtl/lif_spike_encoder_if.sv
// Config/start handshake and spike-output bundle between a stimulus source and lif_spike_encoder.
interface lif_spike_encoder_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_rate;
  logic        cfg_mode;
  logic [15:0] cfg_count;
  logic        start;
  logic        stop;
  logic        spike;
  logic [7:0]  current;
  logic        busy;
  logic        done;
  logic [15:0] emitted;

  modport master (
    output cfg_valid, cfg_rate, cfg_mode, cfg_count, start, stop,
    input  cfg_ready, spike, current, busy, done, emitted
  );

  modport slave (
    input  cfg_valid, cfg_rate, cfg_mode, cfg_count, start, stop,
    output cfg_ready, spike, current, busy, done, emitted
  );
endinterface

// File: rtl/lif_spike_encoder.sv
// Rate-coded spike generator: phase accumulator or LFSR comparator turns an 8-bit
// intensity into one-cycle current pulses, with an optional refractory gap after each spike.
module lif_spike_encoder #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          REFRAC    = 2,
  parameter logic [7:0]  AMP       = 8'd200
) (
  input  logic                clk,
  input  logic                rst,
  lif_spike_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REFRAC = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] REFRAC_LD  = 8'(REFRAC);
  localparam bit         HAS_REFRAC = (REFRAC > 0);

  state_t      state_r, next_state_s;
  logic [15:0] lfsr_r;
  logic [7:0]  acc_r;
  logic [7:0]  rate_r;
  logic        mode_r;
  logic [15:0] count_r;
  logic [7:0]  rcnt_r;
  logic        spike_r, busy_r, done_r;
  logic [7:0]  current_r;
  logic [15:0] emitted_r;

  logic [8:0]  sum_s;
  logic        hit_s, eval_hit_s, last_s, cfg_ready_s, cfg_fire_s, start_fire_s;
  logic [15:0] emitted_inc_s;

  // Galois right-shift step with taps 16'hB400.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  assign sum_s         = {1'b0, acc_r} + {1'b0, rate_r};
  assign hit_s         = mode_r ? (lfsr_r[7:0] < rate_r) : sum_s[8];
  assign emitted_inc_s = emitted_r + 16'd1;
  assign last_s        = (count_r != 16'd0) && (emitted_inc_s == count_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_state_s;
  end

  // Next-state logic; stop outranks a same-cycle hit.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) next_state_s = ST_RUN;
        else           next_state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (bus.stop)       next_state_s = ST_DONE;
        else if (!hit_s)    next_state_s = ST_RUN;
        else if (last_s)    next_state_s = ST_DONE;
        else if (HAS_REFRAC) next_state_s = ST_REFRAC;
        else                next_state_s = ST_RUN;
      end
      ST_REFRAC: begin
        if (bus.stop)              next_state_s = ST_DONE;
        else if (rcnt_r <= 8'd1)   next_state_s = ST_RUN;
        else                       next_state_s = ST_REFRAC;
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output/strobe decode from the state register.
  always_comb begin
    cfg_ready_s  = (state_r == ST_IDLE);
    cfg_fire_s   = bus.cfg_valid && cfg_ready_s;
    start_fire_s = bus.start && cfg_ready_s;
    eval_hit_s   = (state_r == ST_RUN) && !bus.stop && hit_s;
  end

  // Datapath: LFSR, config latch, accumulator, spike counter, refractory counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r    <= LFSR_SEED;
      acc_r     <= 8'd0;
      rate_r    <= 8'd0;
      mode_r    <= 1'b0;
      count_r   <= 16'd0;
      rcnt_r    <= 8'd0;
      emitted_r <= 16'd0;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
      if (cfg_fire_s) begin
        rate_r  <= bus.cfg_rate;
        mode_r  <= bus.cfg_mode;
        count_r <= bus.cfg_count;
      end
      if (start_fire_s) begin
        acc_r     <= 8'd0;
        emitted_r <= 16'd0;
      end else if ((state_r == ST_RUN) && !bus.stop) begin
        acc_r <= sum_s[7:0];
        if (hit_s && (emitted_r != 16'hFFFF)) emitted_r <= emitted_inc_s;
      end
      if (eval_hit_s)                rcnt_r <= REFRAC_LD;
      else if (state_r == ST_REFRAC) rcnt_r <= rcnt_r - 8'd1;
    end
  end

  // Registered outputs; busy/done are timed so busy falls exactly as done rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_r   <= 1'b0;
      current_r <= 8'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      spike_r   <= eval_hit_s;
      current_r <= eval_hit_s ? AMP : 8'd0;
      busy_r    <= (next_state_s != ST_IDLE);
      done_r    <= (state_r == ST_DONE);
    end
  end

  assign bus.cfg_ready = cfg_ready_s;
  assign bus.spike     = spike_r;
  assign bus.current   = current_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.emitted   = emitted_r;

endmodule

// File: tb/tb_lif_spike_encoder.sv
// Directed bench for lif_spike_encoder: dut0 has no refractory gap, dut2 uses REFRAC = 2.
module tb_lif_spike_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_rate  = 8'd0;
  logic        cfg_mode  = 1'b0;
  logic [15:0] cfg_count = 16'd0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic [15:0] m_lfsr;
  int tests_run = 0;
  int tests_failed = 0;

  lif_spike_encoder_if bus0();
  lif_spike_encoder_if bus2();

  assign bus0.cfg_valid = cfg_valid;  assign bus2.cfg_valid = cfg_valid;
  assign bus0.cfg_rate  = cfg_rate;   assign bus2.cfg_rate  = cfg_rate;
  assign bus0.cfg_mode  = cfg_mode;   assign bus2.cfg_mode  = cfg_mode;
  assign bus0.cfg_count = cfg_count;  assign bus2.cfg_count = cfg_count;
  assign bus0.start     = start;      assign bus2.start     = start;
  assign bus0.stop      = stop;       assign bus2.stop      = stop;

  lif_spike_encoder #(.LFSR_SEED(16'hACE1), .REFRAC(0), .AMP(8'd200)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  lif_spike_encoder #(.LFSR_SEED(16'hACE1), .REFRAC(2), .AMP(8'd200)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  // Reference LFSR, stepped from reset on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic configure(input logic [7:0] r, input logic m, input logic [15:0] c);
    cfg_valid = 1'b1; cfg_rate = r; cfg_mode = m; cfg_count = c;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tests_run++;
    if ({bus0.spike, bus0.current, bus0.busy, bus0.done, bus0.emitted} !== 27'd0) begin
      tests_failed++; $display("FAIL reset_hold: got outputs %h required 0", {bus0.spike, bus0.current, bus0.busy, bus0.done, bus0.emitted});
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (bus0.cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cfg_ready: got %b required 1", bus0.cfg_ready); end
    configure(8'd255, 1'b0, 16'd0);
    start_run();
    repeat (5) tick();
    tests_run++;
    if (bus0.emitted !== 16'd4 || bus0.busy !== 1'b1) begin
      tests_failed++; $display("FAIL reset_prerun: got emitted %0d busy %b required 4 1", bus0.emitted, bus0.busy);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus0.spike, bus0.current, bus0.busy, bus0.done, bus0.emitted} !== 27'd0) begin
      tests_failed++; $display("FAIL reset_async: got outputs %h required 0", {bus0.spike, bus0.current, bus0.busy, bus0.done, bus0.emitted});
    end
    tests_run++;
    if (bus2.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_async_dut2: got busy %b required 0", bus2.busy); end
    tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (bus0.cfg_ready !== 1'b1 || bus0.busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_release: got cfg_ready %b busy %b required 1 0", bus0.cfg_ready, bus0.busy);
    end
    repeat (5) tick();
  endtask

  task automatic test_det_count();
    logic exp_sp;
    int dones = 0;
    configure(8'd128, 1'b0, 16'd4);
    start_run();
    tests_run++;
    if (bus0.busy !== 1'b1 || bus0.spike !== 1'b0) begin
      tests_failed++; $display("FAIL det_busy_rise: got busy %b spike %b required 1 0", bus0.busy, bus0.spike);
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_sp = (k == 2) || (k == 4) || (k == 6) || (k == 8);
      dones += int'(bus0.done);
      tests_run++;
      if (bus0.spike !== exp_sp || bus0.current !== (exp_sp ? 8'd200 : 8'd0)) begin
        tests_failed++; $display("FAIL det_spike_E%0d: got spike %b current %0d required %b %0d", k, bus0.spike, bus0.current, exp_sp, exp_sp ? 200 : 0);
      end
      tests_run++;
      if (bus0.done !== (k == 9) || bus0.busy !== (k < 9)) begin
        tests_failed++; $display("FAIL det_done_busy_E%0d: got done %b busy %b required %b %b", k, bus0.done, bus0.busy, k == 9, k < 9);
      end
    end
    tests_run++;
    if (bus0.emitted !== 16'd4 || dones != 1) begin
      tests_failed++; $display("FAIL det_total: got emitted %0d dones %0d required 4 1", bus0.emitted, dones);
    end
    repeat (20) tick();
  endtask

  task automatic test_refrac();
    int n = 0;
    int last = -100;
    int short_gaps = 0;
    int dones = 0;
    logic exp_sp;
    configure(8'd255, 1'b0, 16'd5);
    start_run();
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_sp = (k == 2) || (k == 5) || (k == 8) || (k == 11) || (k == 14);
      dones += int'(bus2.done);
      if (bus2.spike === 1'b1) begin
        if (k - last < 3) short_gaps++;
        last = k;
        n++;
      end
      tests_run++;
      if (bus2.spike !== exp_sp) begin
        tests_failed++; $display("FAIL refrac_spike_E%0d: got %b required %b", k, bus2.spike, exp_sp);
      end
    end
    tests_run++;
    if (n != 5 || bus2.emitted !== 16'd5 || short_gaps != 0 || dones != 1) begin
      tests_failed++; $display("FAIL refrac_total: got spikes %0d emitted %0d short_gaps %0d dones %0d required 5 5 0 1", n, bus2.emitted, short_gaps, dones);
    end
    repeat (10) tick();
  endtask

  task automatic test_rate_zero_stop();
    int n = 0;
    configure(8'd0, 1'b0, 16'd0);
    start_run();
    repeat (1000) begin
      tick();
      n += int'(bus0.spike);
    end
    tests_run++;
    if (n != 0 || bus0.busy !== 1'b1) begin
      tests_failed++; $display("FAIL zero_rate_spikes: got %0d busy %b required 0 1", n, bus0.busy);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests_run++;
    if (bus0.done !== 1'b0 || bus0.busy !== 1'b1) begin
      tests_failed++; $display("FAIL stop_done_early: got done %b busy %b required 0 1", bus0.done, bus0.busy);
    end
    tick();
    tests_run++;
    if (bus0.done !== 1'b1 || bus0.emitted !== 16'd0 || bus0.busy !== 1'b0 || bus0.cfg_ready !== 1'b1) begin
      tests_failed++; $display("FAIL stop_done: got done %b emitted %0d busy %b ready %b required 1 0 0 1", bus0.done, bus0.emitted, bus0.busy, bus0.cfg_ready);
    end
    tick();
    tests_run++;
    if (bus0.done !== 1'b0 || bus0.cfg_ready !== 1'b1) begin
      tests_failed++; $display("FAIL stop_idle: got done %b ready %b required 0 1", bus0.done, bus0.cfg_ready);
    end
    repeat (10) tick();
  endtask

  task automatic test_guards();
    // Latched rate is 0 here, so any early spike proves the same-cycle config was taken.
    cfg_valid = 1'b1; cfg_rate = 8'd128; cfg_mode = 1'b0; cfg_count = 16'd0; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests_run++;
      if (bus0.spike !== ((k % 2) == 0)) begin
        tests_failed++; $display("FAIL simul_cfg_start_E%0d: got spike %b required %b", k, bus0.spike, (k % 2) == 0);
      end
    end
    cfg_valid = 1'b1; cfg_rate = 8'd10; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    tests_run++;
    if (bus0.spike !== 1'b0 || bus0.emitted !== 16'd2 || bus0.cfg_ready !== 1'b0) begin
      tests_failed++; $display("FAIL guard_E5: got spike %b emitted %0d ready %b required 0 2 0", bus0.spike, bus0.emitted, bus0.cfg_ready);
    end
    tick();
    tests_run++;
    if (bus0.spike !== 1'b1 || bus0.emitted !== 16'd3) begin
      tests_failed++; $display("FAIL guard_E6: got spike %b emitted %0d required 1 3", bus0.spike, bus0.emitted);
    end
    tick();
    tick();
    tests_run++;
    if (bus0.spike !== 1'b1 || bus0.emitted !== 16'd4) begin
      tests_failed++; $display("FAIL guard_E8: got spike %b emitted %0d required 1 4", bus0.spike, bus0.emitted);
    end
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests_run++;
    if (bus0.spike !== 1'b0 || bus0.emitted !== 16'd4) begin
      tests_failed++; $display("FAIL stop_priority: got spike %b emitted %0d required 0 4", bus0.spike, bus0.emitted);
    end
    tick();
    tests_run++;
    if (bus0.done !== 1'b1 || bus0.busy !== 1'b0) begin
      tests_failed++; $display("FAIL guard_done: got done %b busy %b required 1 0", bus0.done, bus0.busy);
    end
    repeat (10) tick();
  endtask

  task automatic run_stoch(output int cnt, output int mism, output bit [4095:0] seq);
    logic exp_hit;
    cnt = 0; mism = 0; seq = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    configure(8'd64, 1'b1, 16'd0);
    start_run();
    for (int i = 0; i < 4096; i++) begin
      exp_hit = (m_lfsr[7:0] < 8'd64);
      tick();
      if (bus0.spike !== exp_hit) mism++;
      cnt += int'(bus0.spike);
      seq[i] = bus0.spike;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_stochastic();
    int c1, c2, m1, m2;
    bit [4095:0] s1, s2;
    run_stoch(c1, m1, s1);
    run_stoch(c2, m2, s2);
    tests_run++;
    if (c1 < 900 || c1 > 1150) begin tests_failed++; $display("FAIL stoch_count: got %0d required 900..1150", c1); end
    tests_run++;
    if (m1 != 0 || m2 != 0) begin tests_failed++; $display("FAIL stoch_model: got mismatching cycles %0d %0d required 0 0", m1, m2); end
    tests_run++;
    if (s1 != s2 || c1 != c2) begin tests_failed++; $display("FAIL stoch_repeat: got counts %0d %0d required identical sequences", c1, c2); end
  endtask

  initial begin
    test_reset();
    test_det_count();
    test_refrac();
    test_rate_zero_stop();
    test_guards();
    test_stochastic();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
